// File: rtl/hoeraa_pkg.sv
// Shared types and helpers for the HOERAA pipelined approximate adder.
// The stage-1 payload struct is sized by the package configuration below.
package hoeraa_pkg;

    localparam int HOERAA_N     = 16;
    localparam int HOERAA_L_MAX = 4;
    localparam int HOERAA_LW    = 3;
    localparam int HOERAA_HW    = HOERAA_N / 2;

    typedef struct packed {
        logic [HOERAA_HW-1:0] lo_sum;
        logic                 carry;
        logic [HOERAA_HW-1:0] x_hi;
        logic [HOERAA_HW-1:0] y_hi;
        logic [HOERAA_LW-1:0] le;
    } hoeraa_s1_t;

    // Depth 1 has no room for the two-bit HOERAA cell, so it degrades to exact.
    function automatic logic [HOERAA_LW-1:0] calc_le(input logic [HOERAA_LW-1:0] l,
                                                     input int lmax);
        if (int'(l) > lmax) return HOERAA_LW'(lmax);
        if (l == HOERAA_LW'(1)) return '0;
        return l;
    endfunction

    function automatic logic [HOERAA_HW-1:0] approx_mask(input logic [HOERAA_LW-1:0] le);
        return (HOERAA_HW'(1) << le) - HOERAA_HW'(1);
    endfunction

endpackage

// File: rtl/hoeraa_lo_stage.sv
// Combinational low-half of the HOERAA adder: approximate bits below Le,
// exact sum of the remaining low-half bits, and the carry into the upper half.
module hoeraa_lo_stage
    import hoeraa_pkg::*;
(
    input  logic [HOERAA_HW-1:0] x_lo_i,
    input  logic [HOERAA_HW-1:0] y_lo_i,
    input  logic [HOERAA_LW-1:0] le_i,
    output logic [HOERAA_HW-1:0] sum_o,
    output logic                 carry_o
);

    localparam int IW = $clog2(HOERAA_HW);

    logic [HOERAA_HW-1:0] mask;
    logic [HOERAA_HW-1:0] apx;
    logic [HOERAA_HW:0]   ex;
    logic [IW-1:0]        i1;
    logic [IW-1:0]        i2;
    logic                 ci;

    always_comb begin
        mask = approx_mask(le_i);
        ci   = 1'b0;
        apx  = '0;
        i1   = IW'(le_i - HOERAA_LW'(1));
        i2   = IW'(le_i - HOERAA_LW'(2));
        if (le_i >= HOERAA_LW'(2)) begin
            ci  = x_lo_i[i1] & y_lo_i[i1];
            apx = approx_mask(le_i - HOERAA_LW'(2))
                | (HOERAA_HW'(x_lo_i[i2] | y_lo_i[i2]) << i2)
                | (HOERAA_HW'(ci ? (x_lo_i[i2] & y_lo_i[i2])
                                 : (x_lo_i[i1] | y_lo_i[i1])) << i1);
        end
        // Masked operands leave bits below Le zero, so Ci lands exactly at bit Le.
        ex      = {1'b0, x_lo_i & ~mask} + {1'b0, y_lo_i & ~mask}
                + ((HOERAA_HW+1)'(ci) << le_i);
        sum_o   = (ex[HOERAA_HW-1:0] & ~mask) | (apx & mask);
        carry_o = ex[HOERAA_HW];
    end

endmodule

// File: rtl/hoeraa_rca.sv
// Ripple-carry adder built from a chain of full-adder cells.
module hoeraa_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[W];

endmodule

// File: rtl/hoeraa_pipe.sv
// Two-stage pipelined HOERAA approximate adder with valid/ready on both sides.
// Optional error statistics enabled by defining HOERAA_ERR_STATS_EN.
module hoeraa_pipe
    import hoeraa_pkg::*;
#(
    parameter int N     = HOERAA_N,
    parameter int L_MAX = HOERAA_L_MAX,
    parameter int LW    = HOERAA_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_y,
    input  logic [LW-1:0] in_l,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_s,
    output logic          out_co
`ifdef HOERAA_ERR_STATS_EN
    ,
    output logic [N:0]    err_dist,
    output logic [31:0]   err_cnt
`endif
);

    localparam int HW = N / 2;

    hoeraa_s1_t   pay_p1_d, pay_p1_q;
    logic         vld_p1_q, vld_p2_q;
    logic [N-1:0] sum_p2_q;
    logic         co_p2_q;
    logic         ld_p1, ld_p2;
    logic [LW-1:0] le_p0;
    logic [HW-1:0] lo_sum_p0;
    logic          lo_c_p0;
    logic [HW-1:0] hi_sum_p1;
    logic          hi_co_p1;
    logic          unused_le;

    assign ld_p2     = !vld_p2_q || out_ready;
    assign ld_p1     = !vld_p1_q || ld_p2;
    assign in_ready  = ld_p1;
    assign out_valid = vld_p2_q;
    assign out_s     = sum_p2_q;
    assign out_co    = co_p2_q;
    assign le_p0     = calc_le(in_l, L_MAX);
    assign unused_le = ^pay_p1_q.le;

    // Stage 0 -> 1: low half and carry into bit N/2
    hoeraa_lo_stage u_lo (
        .x_lo_i  (in_x[HW-1:0]),
        .y_lo_i  (in_y[HW-1:0]),
        .le_i    (le_p0),
        .sum_o   (lo_sum_p0),
        .carry_o (lo_c_p0)
    );

    always_comb begin
        pay_p1_d        = pay_p1_q;
        pay_p1_d.lo_sum = lo_sum_p0;
        pay_p1_d.carry  = lo_c_p0;
        pay_p1_d.x_hi   = in_x[N-1:HW];
        pay_p1_d.y_hi   = in_y[N-1:HW];
        pay_p1_d.le     = le_p0;
    end

    always_ff @(posedge clk) begin
        if (ld_p1 && in_valid) pay_p1_q <= pay_p1_d;
    end

    // Stage 1 -> 2: upper half ripple add
    hoeraa_rca #(.W(HW)) u_hi (
        .a_i (pay_p1_q.x_hi),
        .b_i (pay_p1_q.y_hi),
        .c_i (pay_p1_q.carry),
        .s_o (hi_sum_p1),
        .c_o (hi_co_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sum_p2_q <= '0;
            co_p2_q  <= 1'b0;
        end else begin
            if (ld_p1) vld_p1_q <= in_valid;
            if (ld_p2) vld_p2_q <= vld_p1_q;
            if (ld_p2 && vld_p1_q) begin
                sum_p2_q <= {hi_sum_p1, pay_p1_q.lo_sum};
                co_p2_q  <= hi_co_p1;
            end
        end
    end

`ifdef HOERAA_ERR_STATS_EN
    logic [N:0] exact_p1_q, exact_p2_q;
    logic [N:0] apx_p2;

    always_ff @(posedge clk) begin
        if (ld_p1 && in_valid)  exact_p1_q <= {1'b0, in_x} + {1'b0, in_y};
        if (ld_p2 && vld_p1_q)  exact_p2_q <= exact_p1_q;
    end

    assign apx_p2   = {co_p2_q, sum_p2_q};
    assign err_dist = (exact_p2_q >= apx_p2) ? (exact_p2_q - apx_p2) : (apx_p2 - exact_p2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (vld_p2_q && out_ready && (err_dist != '0) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hoeraa_pipe.sv
// Self-checking bench for hoeraa_pipe: directed vectors plus a reference model.
module tb_hoeraa_pipe;

    localparam int N  = 16;
    localparam int LW = 3;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_x = '0;
    logic [N-1:0]  in_y = '0;
    logic [LW-1:0] in_l = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_s;
    logic          out_co;
`ifdef HOERAA_ERR_STATS_EN
    logic [N:0]    err_dist;
    logic [31:0]   err_cnt;
`endif

    hoeraa_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_l      (in_l),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_co    (out_co)
`ifdef HOERAA_ERR_STATS_EN
        ,
        .err_dist  (err_dist),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference: HOERAA rule applied to whole words with shifts
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input int l);
        int le;
        logic [N-1:0] xs1, ys1, xs2, ys2, lo;
        logic ci, b1, b2;
        logic [N:0] hi;
        le = (l > LM) ? LM : l;
        if (le == 1) le = 0;
        if (le == 0) return {1'b0, x} + {1'b0, y};
        xs1 = x >> (le - 1);
        ys1 = y >> (le - 1);
        xs2 = x >> (le - 2);
        ys2 = y >> (le - 2);
        ci  = xs1[0] & ys1[0];
        b2  = xs2[0] | ys2[0];
        b1  = ci ? (xs2[0] & ys2[0]) : (xs1[0] | ys1[0]);
        lo  = ((N'(1) << (le - 2)) - N'(1)) | (N'(b2) << (le - 2)) | (N'(b1) << (le - 1));
        hi  = ({1'b0, x} >> le) + ({1'b0, y} >> le) + (N+1)'(ci);
        return (hi << le) | {1'b0, lo};
    endfunction

    function automatic logic [N:0] absd(input logic [N:0] a, input logic [N:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N:0] r;
        logic [N:0] ex;
        int         acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   inflight   = 0;
    bit   mon_en     = 1'b0;
    bit   chk_lat    = 1'b0;
    bit   stall_prev = 1'b0;
    logic [N:0] held = '0;
    int   model_cnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            inflight   = 0;
            stall_prev = 1'b0;
            model_cnt  = 0;
        end else if (mon_en) begin
            check("in_ready", 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_co, out_s}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    nvec = nvec + 1;
                    nerr = nerr + 1;
                    $display("FAIL spurious_out: got %0h, expected no beat", {out_co, out_s});
                end else begin
                    e = q.pop_front();
                    check("sum", 64'({out_co, out_s}), 64'(e.r));
                    if (chk_lat) check("latency", 64'(cyc - e.acc), 64'd2);
`ifdef HOERAA_ERR_STATS_EN
                    check("err_dist", 64'(err_dist), 64'(absd(e.ex, e.r)));
                    check("err_cnt", 64'(err_cnt), 64'(model_cnt));
                    if (absd(e.ex, e.r) != '0) model_cnt = model_cnt + 1;
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_co, out_s};
            if (in_valid && in_ready) begin
                q.push_back('{model(in_x, in_y, int'(in_l)), {1'b0, in_x} + {1'b0, in_y}, cyc});
            end
            inflight = inflight + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [LW-1:0] l);
        int t;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_l     = l;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 50) begin
            nvec = nvec + 1;
            nerr = nerr + 1;
            $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [N:0] lit, input logic [N:0] edist);
        int t;
        for (t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) break;
        end
        if (t == 10) begin
            nvec = nvec + 1;
            nerr = nerr + 1;
            $display("FAIL %s_timeout: out_valid stayed %0b, expected 1", name, out_valid);
        end else begin
            check(name, 64'({out_co, out_s}), 64'(lit));
`ifdef HOERAA_ERR_STATS_EN
            check({name, "_err"}, 64'(err_dist), 64'(edist));
`else
            if (edist == '1) $display("unexpected distance marker");
`endif
        end
        @(posedge clk);
        #1;
    endtask

    bit pat_en = 1'b0;
    int pidx   = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pat_en) begin
                out_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
                pidx = pidx + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        check("model_exact", 64'(model(16'hFFFF, 16'h0001, 0)), 64'h10000);
        check("model_l4a",   64'(model(16'h00FF, 16'h0001, 4)), 64'h000FF);
        check("model_l4b",   64'(model(16'h0008, 16'h0008, 4)), 64'h00013);
        check("model_l7",    64'(model(16'h0008, 16'h0008, 7)), 64'h00013);
        check("model_l1",    64'(model(16'h0008, 16'h0008, 1)), 64'h00010);
        check("model_l2",    64'(model(16'h1234, 16'h4321, 2)), 64'h05555);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_s",     64'(out_s),     64'd0);
        check("rst_out_co",    64'(out_co),    64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        chk_lat   = 1'b1;
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 3'd0);
        expect_out("exact_wrap", 17'h10000, 17'd0);
        send(16'h00FF, 16'h0001, 3'd4);
        expect_out("l4_ff", 17'h000FF, 17'd1);
`ifdef HOERAA_ERR_STATS_EN
        check("err_cnt_lit", 64'(err_cnt), 64'd1);
`endif
        send(16'h0008, 16'h0008, 3'd4);
        expect_out("l4_ci", 17'h00013, 17'd3);
        send(16'h0008, 16'h0008, 3'd7);
        expect_out("l7_clamp", 17'h00013, 17'd3);
        send(16'h0008, 16'h0008, 3'd1);
        expect_out("l1_exact", 17'h00010, 17'd0);

        chk_lat = 1'b0;
        pidx    = 0;
        pat_en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(N'($urandom), N'($urandom), LW'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            nvec = nvec + 1;
            nerr = nerr + 1;
            $display("FAIL drain: %0d beats outstanding, expected 0", q.size());
        end
        @(posedge clk);
        #1;
        pat_en    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(16'hAAAA, 16'h5555, 3'd3);
        send(16'h0F0F, 16'hF0F0, 3'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_s",     64'(out_s),     64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        send(16'h1234, 16'h4321, 3'd2);
        expect_out("post_rst", 17'h05555, 17'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
